// File: rtl/greenhouse_pkg.sv
// rtl/greenhouse_pkg.sv - shared greenhouse menu encodings and time limits
package greenhouse_pkg;

  typedef enum logic [1:0] {
    ST_TEMP    = 2'd0,
    ST_HUM     = 2'd1,
    ST_HOURS   = 2'd2,
    ST_MINUTES = 2'd3
  } menu_state_e;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;
  localparam logic [5:0] SECONDS_MAX = 6'd59;

  // Menu order: TEMP -> HUM -> HOURS -> MINUTES -> TEMP
  function automatic menu_state_e next_menu_state(input menu_state_e cur);
    case (cur)
      ST_TEMP:    return ST_HUM;
      ST_HUM:     return ST_HOURS;
      ST_HOURS:   return ST_MINUTES;
      default:    return ST_TEMP;
    endcase
  endfunction

  // One step up or down on a 0..max_v wrapping field
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer, debouncer, press pulse and auto-repeat for one button
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_event
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          db_q;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  logic          rep_phase;

  logic db_flip;
  logic press_set;
  logic release_set;
  logic rep_fire;

  // The level flips once the synchronized input has disagreed for DEBOUNCE_CYCLES samples
  assign db_flip     = (sync_q2 != db_q) && (db_cnt == DB_LAST);
  assign press_set   = db_flip && sync_q2;
  assign release_set = db_flip && !sync_q2;
  // A repeat landing on the release edge is dropped so release never emits an event
  assign rep_fire    = REPEAT_EN && db_q && !release_set &&
                       (rep_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST));

  // Two-flop synchronizer for the asynchronous raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce counter runs only while the input disagrees with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else if (sync_q2 == db_q) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_q   <= sync_q2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Repeat timer: first interval is REPEAT_DELAY, subsequent ones REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (!db_q || !REPEAT_EN) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Registered one-cycle event for the initial press and each repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press_event <= 1'b0;
    else        press_event <= press_set || rep_fire;
  end

endmodule

// File: rtl/menu_controller.sv
// rtl/menu_controller.sv - greenhouse setpoint/clock menu driven by three pushbuttons
module menu_controller
  import greenhouse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int          TEMP_MIN        = 32,
  parameter int          TEMP_MAX        = 110,
  parameter int          TEMP_DEFAULT    = 72,
  parameter int          HUM_MIN         = 0,
  parameter int          HUM_MAX         = 99,
  parameter int          HUM_DEFAULT     = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_select,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        tick_1hz,
  output logic [3:0]  state,
  output logic [11:0] set_temp,
  output logic [7:0]  set_hum,
  output logic [4:0]  time_hours,
  output logic [5:0]  time_minutes
);

  localparam logic [11:0] TEMP_MIN_V = 12'(TEMP_MIN);
  localparam logic [11:0] TEMP_MAX_V = 12'(TEMP_MAX);
  localparam logic [11:0] TEMP_DEF_V = 12'(TEMP_DEFAULT);
  localparam logic [7:0]  HUM_MIN_V  = 8'(HUM_MIN);
  localparam logic [7:0]  HUM_MAX_V  = 8'(HUM_MAX);
  localparam logic [7:0]  HUM_DEF_V  = 8'(HUM_DEFAULT);

  logic sel_ev;
  logic up_ev;
  logic down_ev;
  logic up_eff;
  logic down_eff;

  menu_state_e state_q;
  menu_state_e state_d;
  logic [5:0]  seconds_q;

  logic [11:0] temp_d;
  logic [7:0]  hum_d;
  logic [4:0]  hours_d;
  logic [5:0]  minutes_d;
  logic [5:0]  seconds_d;
  logic        sec_wrap;
  logic        min_wrap;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b0)
  ) u_btn_select (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn_select),
    .press_event(sel_ev)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b1)
  ) u_btn_up (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn_up),
    .press_event(up_ev)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b1)
  ) u_btn_down (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn_down),
    .press_event(down_ev)
  );

  // Simultaneous up+down cancel; any select in the same cycle swallows the edit
  assign up_eff   = up_ev && !down_ev && !sel_ev;
  assign down_eff = down_ev && !up_ev && !sel_ev;

  assign sec_wrap = tick_1hz && (seconds_q == SECONDS_MAX);
  assign min_wrap = sec_wrap && (time_minutes == MINUTES_MAX);

  assign state = {2'b00, state_q};

  // Menu state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_TEMP;
    else        state_q <= state_d;
  end

  // Menu next-state: select walks the menu ring
  always_comb begin
    state_d = state_q;
    if (sel_ev) state_d = next_menu_state(state_q);
  end

  // Field next values: clock carries first, then a user edit overrides its own field
  always_comb begin
    temp_d    = set_temp;
    hum_d     = set_hum;
    hours_d   = time_hours;
    minutes_d = time_minutes;
    seconds_d = seconds_q;

    if (tick_1hz) seconds_d = step_wrap(seconds_q, SECONDS_MAX, 1'b1);
    if (sec_wrap) minutes_d = step_wrap(time_minutes, MINUTES_MAX, 1'b1);
    if (min_wrap) hours_d   = 5'(step_wrap({1'b0, time_hours}, {1'b0, HOURS_MAX}, 1'b1));

    if (up_eff || down_eff) begin
      case (state_q)
        ST_TEMP: begin
          if (up_eff && set_temp < TEMP_MAX_V)   temp_d = set_temp + 12'd1;
          if (down_eff && set_temp > TEMP_MIN_V) temp_d = set_temp - 12'd1;
        end
        ST_HUM: begin
          if (up_eff && set_hum < HUM_MAX_V)   hum_d = set_hum + 8'd1;
          if (down_eff && set_hum > HUM_MIN_V) hum_d = set_hum - 8'd1;
        end
        ST_HOURS: begin
          hours_d = 5'(step_wrap({1'b0, time_hours}, {1'b0, HOURS_MAX}, up_eff));
        end
        default: begin
          minutes_d = step_wrap(time_minutes, MINUTES_MAX, up_eff);
          seconds_d = 6'd0;
        end
      endcase
    end
  end

  // Setpoint and clock registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_temp     <= TEMP_DEF_V;
      set_hum      <= HUM_DEF_V;
      time_hours   <= 5'd0;
      time_minutes <= 6'd0;
      seconds_q    <= 6'd0;
    end else begin
      set_temp     <= temp_d;
      set_hum      <= hum_d;
      time_hours   <= hours_d;
      time_minutes <= minutes_d;
      seconds_q    <= seconds_d;
    end
  end

endmodule

// File: tb/tb_menu_controller.sv
// tb/tb_menu_controller.sv - self-checking bench for menu_controller
module tb_menu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_select;
  logic        btn_up;
  logic        btn_down;
  logic        tick_1hz;
  logic [3:0]  state;
  logic [11:0] set_temp;
  logic [7:0]  set_hum;
  logic [4:0]  time_hours;
  logic [5:0]  time_minutes;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic sel;
    logic up;
    logic dn;
    int   hold;
    int   st;
    int   temp;
    int   hum;
    int   hr;
    int   mn;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  menu_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_select  (btn_select),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .tick_1hz    (tick_1hz),
    .state       (state),
    .set_temp    (set_temp),
    .set_hum     (set_hum),
    .time_hours  (time_hours),
    .time_minutes(time_minutes)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int temp, input int hum,
                         input int hr, input int mn);
    chk($sformatf("%s.state", tag), int'(state), st);
    chk($sformatf("%s.set_temp", tag), int'(set_temp), temp);
    chk($sformatf("%s.set_hum", tag), int'(set_hum), hum);
    chk($sformatf("%s.hours", tag), int'(time_hours), hr);
    chk($sformatf("%s.minutes", tag), int'(time_minutes), mn);
  endtask

  task automatic press(input logic s, input logic u, input logic d, input int hold);
    @(posedge clk);
    #1;
    btn_select = s;
    btn_up     = u;
    btn_down   = d;
    repeat (hold) @(posedge clk);
    #1;
    btn_select = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 tick_1hz = 1'b1;
      @(posedge clk);
      #1 tick_1hz = 1'b0;
    end
  endtask

  initial begin
    //           sel   up    dn    hold st temp hum hr mn
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 10, 0, 73, 50, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3,  0, 73, 50, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10, 0, 72, 50, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 10, 0, 72, 50, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 1, 72, 50, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 10, 1, 72, 49, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 10, 2, 72, 49, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 10, 2, 72, 49, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10, 2, 72, 49, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 10, 2, 72, 49, 23, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10, 2, 72, 49, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 10, 3, 72, 49, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10, 3, 72, 49, 0, 59};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 10, 3, 72, 49, 0, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 10, 0, 72, 49, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 40, 0, 77, 49, 0, 0};

    rst_n      = 1'b0;
    btn_select = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    tick_1hz   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 72, 50, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      press(vecs[i].sel, vecs[i].up, vecs[i].dn, vecs[i].hold);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].temp, vecs[i].hum,
              vecs[i].hr, vecs[i].mn);
    end

    // Saturation at TEMP_MAX and HUM_MIN under auto-repeat
    press(1'b0, 1'b1, 1'b0, 300);
    chk("temp_sat_long", int'(set_temp), 110);
    press(1'b0, 1'b0, 1'b1, 10);
    chk("temp_109", int'(set_temp), 109);
    press(1'b0, 1'b1, 1'b0, 60);
    chk("temp_sat_110", int'(set_temp), 110);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 300);
    chk_all("hum_sat_long", 1, 110, 0, 0, 0);
    press(1'b0, 1'b0, 1'b1, 10);
    chk("hum_min_hold", int'(set_hum), 0);
    press(1'b1, 1'b0, 1'b0, 40);
    chk("select_no_repeat", int'(state), 2);

    // Minute edit clears seconds; full-day rollover by ticks
    press(1'b0, 1'b0, 1'b1, 10);
    chk("hours_23", int'(time_hours), 23);
    press(1'b1, 1'b0, 1'b0, 10);
    tick_n(30);
    press(1'b0, 1'b0, 1'b1, 10);
    chk_all("min_edit_59", 3, 110, 0, 23, 59);
    tick_n(59);
    chk_all("tick59_no_carry", 3, 110, 0, 23, 59);
    tick_n(1);
    chk_all("midnight_rollover", 3, 110, 0, 0, 0);

    // Tick carry coinciding with a minute edit at 23:59:59
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    chk_all("setup_2359", 3, 110, 0, 23, 59);
    tick_n(59);
    @(posedge clk);
    #1 btn_up = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("edit_tick_pre", int'(time_minutes), 59);
    tick_1hz = 1'b1;
    @(posedge clk);
    #1 tick_1hz = 1'b0;
    chk("edit_tick.minutes", int'(time_minutes), 0);
    chk("edit_tick.hours", int'(time_hours), 0);
    repeat (3) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_all("edit_tick_settled", 3, 110, 0, 0, 0);

    // Asynchronous reset during auto-repeat, button held through release
    press(1'b1, 1'b0, 1'b0, 10);
    chk("back_to_temp", int'(state), 0);
    @(posedge clk);
    #1 btn_up = 1'b1;
    repeat (35) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("reset_async", 0, 72, 50, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_wait", int'(set_temp), 72);
    @(posedge clk);
    #1;
    chk("post_reset_event", int'(set_temp), 73);
    repeat (8) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_all("post_reset_settled", 0, 73, 50, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/menu_controller.md
MENU_CONTROLLER -- requirements
Module: menu_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000; raw-button stable time, in clk cycles, before a level change is accepted.
REQ-002 Parameter REPEAT_DELAY, default 12500000; hold time before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 2500000; auto-repeat step interval.
REQ-004 Parameters TEMP_MIN/TEMP_MAX/TEMP_DEFAULT, defaults 32/110/72; temperature setpoint range and reset value.
REQ-005 Parameters HUM_MIN/HUM_MAX/HUM_DEFAULT, defaults 0/99/50; humidity setpoint range and reset value.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 btn_select, btn_up, btn_down  input  1 each  raw active-high pushbuttons, asynchronous to clk.
REQ-009 tick_1hz  input  1  single-cycle pulse once per second, synchronous to clk.
REQ-010 state  output  4  menu state: 0 TEMP, 1 HUM, 2 HOURS, 3 MINUTES; bits [3:2] always 0.
REQ-011 set_temp  output  12  temperature setpoint, binary.
REQ-012 set_hum  output  8  humidity setpoint, binary.
REQ-013 time_hours  output  5  hours, 0-23.
REQ-014 time_minutes  output  6  minutes, 0-59.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized input has held the new level for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; release generates no event.
REQ-017 While up or down stays debounced-high, a further event SHALL fire REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until release; select never repeats.
REQ-018 A select event SHALL advance state 0->1->2->3->0.
REQ-019 An up/down event SHALL act on the field of the current state: TEMP +/-1 saturating at TEMP_MIN/TEMP_MAX; HUM +/-1 saturating at HUM_MIN/HUM_MAX; HOURS +/-1 wrapping 23<->0; MINUTES +/-1 wrapping 59<->0, with the internal seconds counter cleared.
REQ-020 Up and down events in the same cycle SHALL cancel (no change); up/down events in the same cycle as a select event SHALL be ignored.
REQ-021 tick_1hz SHALL increment a 6-bit internal seconds counter; 59->0 carries into minutes; minutes 59->0 carries into hours; 23:59:59 -> 00:00:00.
REQ-022 A user edit of hours or minutes SHALL override a tick carry into the same field in the same cycle; the carry into the other field SHALL still apply.
REQ-023 All outputs SHALL be registered; a field SHALL update on the clk edge after its event pulse, no earlier than DEBOUNCE_CYCLES and no later than DEBOUNCE_CYCLES+4 cycles after a stable raw press.
REQ-024 Presses shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-025 On rst_n low, asynchronously: state=0, set_temp=TEMP_DEFAULT, set_hum=HUM_DEFAULT, time and seconds=0, synchronizer/debounce/repeat registers=0.
REQ-026 A button held through reset release SHALL produce one event only after DEBOUNCE_CYCLES of post-reset stability.

Structure
REQ-027 The state encodings (TEMP/HUM/HOURS/MINUTES) and the time limits 23/59 SHALL be defined in the shared greenhouse constants package used by the display blocks.
REQ-028 One sub-module, button_debounce (synchronizer + debouncer + press pulse + optional repeat), SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Reset, then up held 10 cycles in state 0 -> set_temp 72->73; 3-cycle glitch -> no change.
REQ-030 State 0, set_temp=109, up held 60 cycles -> 110 and saturates (no wrap); down from HUM_MIN in state 1 -> stays 0.
REQ-031 Four select presses -> state 1,2,3,0; up in state 2 at hours 23 -> 0; down in state 3 at minutes 0 -> 59 and seconds=0.
REQ-032 Time 23:59, seconds 59, tick_1hz -> 00:00; same cycle with an up in MINUTES -> minutes=00 (edit from 59), hours increments to 0.
REQ-033 Up and down pressed together -> no field change; select plus up same cycle -> state advances, value unchanged.
REQ-034 rst_n asserted mid-auto-repeat -> outputs at defaults immediately; held button yields one event after 4 stable post-reset cycles.
